// File: rtl/fc_util_pkg.sv
// Shared FC receive definitions: ordered-set words, deframer state encoding and FIFO beat layout.
package fc_util;

   localparam logic [31:0] SOFI3 = 32'hBCB5_5656;
   localparam logic [31:0] SOFN3 = 32'hBCB5_3636;
   localparam logic [31:0] EOFT  = 32'hBC95_7575;
   localparam logic [31:0] EOFN  = 32'hBC95_D5D5;
   localparam logic [31:0] IDLE  = 32'hBC95_B5B5;

   localparam int FIFO_W = 35;

   typedef enum logic [1:0] {
      HUNT  = 2'd0,
      FRAME = 2'd1,
      DROP  = 2'd2
   } rx_deframe_state_t;

   // One FIFO entry; sop sits in the MSB so the packed layout is {sop,eop,err,data}.
   typedef struct packed {
      logic        sop;
      logic        eop;
      logic        err;
      logic [31:0] data;
   } rx_beat_t;

endpackage

// File: rtl/fc_rx_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered output stage.
// count_o includes the word held in the output register.
module fc_rx_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 35
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic [W-1:0]             push_data_i,
   input  logic                     pop_i,
   output logic [W-1:0]             rd_data_o,
   output logic                     rd_valid_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   mcnt_q, mcnt_d;
   logic [W-1:0]  out_q;
   logic          out_vld_q;
   logic          pop, load, wr;

   assign pop     = pop_i && out_vld_q;
   assign load    = (mcnt_q != '0) && (!out_vld_q || pop);
   // A pop in the same cycle frees a slot, so a push on a full FIFO still lands.
   assign wr      = push_i && ((count_o < DEPTH_C) || pop);
   assign count_o = mcnt_q + {{AW{1'b0}}, out_vld_q};
   assign mcnt_d  = mcnt_q + {{AW{1'b0}}, wr} - {{AW{1'b0}}, load};

   always_ff @(posedge clk) begin
      if (wr) mem_q[wptr_q] <= push_data_i;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         mcnt_q    <= '0;
         out_q     <= '0;
         out_vld_q <= 1'b0;
      end else begin
         if (wr) wptr_q <= wptr_q + AW'(1);
         if (load) begin
            out_q     <= mem_q[rptr_q];
            rptr_q    <= rptr_q + AW'(1);
            out_vld_q <= 1'b1;
         end else if (pop) begin
            out_vld_q <= 1'b0;
         end
         mcnt_q <= mcnt_d;
      end
   end

   assign rd_data_o  = out_q;
   assign rd_valid_o = out_vld_q;

endmodule

// File: rtl/fc_rx_deframer.sv
// FC receive deframer: delimits SOF..EOF frames into Avalon-ST beats through fc_rx_fifo.
// Optional FC_RX_STATS_EN adds good/errored frame counters on the popped eop beats.
//   state | meaning
//   HUNT  | between frames, waiting for SOF with link active
//   FRAME | collecting words; last word parked in hold until its successor or EOF arrives
//   DROP  | frame aborted (too long or FIFO full), discarding until EOF or SOF
module fc_rx_deframer
   import fc_util::*;
#(
   parameter int FIFO_DEPTH      = 16,
   parameter int MAX_FRAME_WORDS = 537
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] rx_data,
   input  logic [3:0]  rx_datak,
   input  logic        rx_code_err,
   input  logic        link_active,
   output logic [31:0] avrx_data,
   output logic        avrx_valid,
   input  logic        avrx_ready,
   output logic        avrx_startofpacket,
   output logic        avrx_endofpacket,
   output logic        avrx_error,
   output logic [31:0] stat_frames,
   output logic [31:0] stat_errors
);

   localparam int CW  = $clog2(FIFO_DEPTH) + 1;
   localparam int WCW = $clog2(MAX_FRAME_WORDS + 1);
   localparam logic [CW-1:0]  FULL_TH = CW'(FIFO_DEPTH - 1);
   localparam logic [CW-1:0]  ROOM_TH = CW'(FIFO_DEPTH);
   localparam logic [WCW-1:0] MAX_WC  = WCW'(MAX_FRAME_WORDS);

   rx_deframe_state_t state_q, state_d;
   logic [31:0]    hold_q, hold_d;
   logic           hold_vld_q, hold_vld_d;
   logic           first_q, first_d;
   logic           err_q, err_d;
   logic [WCW-1:0] wcnt_q, wcnt_d;

   logic is_sof, is_eof, is_data, is_other, need_push, abort;
   logic fifo_full, fifo_room, push, pop;
   rx_beat_t          push_beat;
   logic [FIFO_W-1:0] fifo_rd;
   logic [CW-1:0]     fifo_count;

   assign is_sof    = (rx_datak == 4'b1000) && (rx_data == SOFI3 || rx_data == SOFN3);
   assign is_eof    = (rx_datak == 4'b1000) && (rx_data == EOFT || rx_data == EOFN);
   assign is_data   = (rx_datak == 4'b0000);
   assign is_other  = !is_sof && !is_eof && !is_data;
   assign fifo_full = (fifo_count >= FULL_TH);
   assign fifo_room = (fifo_count < ROOM_TH);
   assign need_push = (is_data && hold_vld_q) || is_eof;
   assign abort     = (state_q == FRAME) &&
                      (!link_active || is_sof || is_other ||
                       (is_data && wcnt_q == MAX_WC) || (need_push && fifo_full));

   always_ff @(posedge clk) begin
      if (reset) state_q <= HUNT;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         HUNT:  if (is_sof && link_active) state_d = FRAME;
         FRAME: begin
            if (!link_active || is_other) state_d = HUNT;
            else if (is_sof)              state_d = FRAME;
            else if (abort)               state_d = DROP;
            else if (is_eof)              state_d = HUNT;
         end
         DROP: begin
            if (is_sof && link_active) state_d = FRAME;
            else if (is_eof)           state_d = HUNT;
         end
         default: state_d = HUNT;
      endcase
   end

   always_comb begin
      push       = (state_q == FRAME) && (abort || is_eof || (is_data && hold_vld_q)) && fifo_room;
      push_beat  = '{sop: 1'b1, eop: 1'b1, err: 1'b1, data: 32'h0};
      if (hold_vld_q) begin
         push_beat.data = hold_q;
         push_beat.sop  = first_q;
         push_beat.eop  = abort || is_eof;
         push_beat.err  = abort || (is_eof && err_q);
      end

      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      first_d    = first_q;
      err_d      = err_q;
      wcnt_d     = wcnt_q;
      if (is_sof && link_active) begin
         hold_vld_d = 1'b0;
         first_d    = 1'b1;
         err_d      = 1'b0;
         wcnt_d     = '0;
      end else if (state_q == FRAME && state_d == FRAME) begin
         hold_d     = rx_data;
         hold_vld_d = 1'b1;
         first_d    = first_q && !push;
         err_d      = err_q || rx_code_err;
         wcnt_d     = wcnt_q + WCW'(1);
      end else if (state_d != FRAME) begin
         hold_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         first_q    <= 1'b0;
         err_q      <= 1'b0;
         wcnt_q     <= '0;
      end else begin
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         first_q    <= first_d;
         err_q      <= err_d;
         wcnt_q     <= wcnt_d;
      end
   end

   fc_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(FIFO_W)) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push),
      .push_data_i (push_beat),
      .pop_i       (pop),
      .rd_data_o   (fifo_rd),
      .rd_valid_o  (avrx_valid),
      .count_o     (fifo_count)
   );

   assign pop                = avrx_valid && avrx_ready;
   assign avrx_data          = fifo_rd[31:0];
   assign avrx_error         = fifo_rd[32];
   assign avrx_endofpacket   = fifo_rd[33];
   assign avrx_startofpacket = fifo_rd[34];

`ifdef FC_RX_STATS_EN
   logic [31:0] stat_frames_q, stat_errors_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_frames_q <= '0;
         stat_errors_q <= '0;
      end else if (pop && avrx_endofpacket) begin
         if (avrx_error) stat_errors_q <= stat_errors_q + 32'd1;
         else            stat_frames_q <= stat_frames_q + 32'd1;
      end
   end

   assign stat_frames = stat_frames_q;
   assign stat_errors = stat_errors_q;
`else
   assign stat_frames = '0;
   assign stat_errors = '0;
`endif

endmodule
